match_judge: RTL

//   Parametrised successor to the single-rally judge: owns full match flow for two players.

---
 rtl/match_judge_pkg.sv | 22 ++
 rtl/match_judge_touch_counter.sv | 50 +++++
 rtl/match_judge.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/match_judge_pkg.sv
// Shared types and helpers for the match judge: FSM state encoding, side constants
// and the win rule.
package match_judge_pkg;

  typedef enum logic [1:0] {
    ST_SERVE     = 2'd0,
    ST_RALLY     = 2'd1,
    ST_PAUSE     = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_t;

  localparam logic PL1 = 1'b0;
  localparam logic PL2 = 1'b1;

  // A saturated score ends the match even without the two-point lead.
  function automatic logic has_won(input int me, input int opp, input int win_points,
                                   input logic win_by_two, input int max_score);
    return (me >= max_score) ||
           ((me >= win_points) && (!win_by_two || (me - opp >= 2)));
  endfunction

endpackage

// File: rtl/match_judge_touch_counter.sv
// Player-collision edge detection, same-side consecutive touch counting and
// over-touch detection for one rally.
module match_judge_touch_counter
  import match_judge_pkg::*;
#(
  parameter int MAX_TOUCHES = 3
) (
  input  logic pclk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic pl1_col,
  input  logic pl2_col,
  output logic last_touch,
  output logic over_touch,
  output logic over_side
);
  localparam int CW = $clog2(MAX_TOUCHES + 2);

  logic          pl1_q, pl2_q, pl1_edge, pl2_edge, one_edge, side;
  logic [CW-1:0] cnt;

  assign pl1_edge = pl1_col & ~pl1_q;
  assign pl2_edge = pl2_col & ~pl2_q;
  // Both players touching in the same cycle is ambiguous and is dropped.
  assign one_edge = pl1_edge ^ pl2_edge;
  assign side     = pl2_edge ? PL2 : PL1;

  assign over_touch = en && one_edge && (side == last_touch) && (cnt == CW'(MAX_TOUCHES));
  assign over_side  = side;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      pl1_q      <= 1'b0;
      pl2_q      <= 1'b0;
      cnt        <= '0;
      last_touch <= PL1;
    end else begin
      pl1_q <= pl1_col;
      pl2_q <= pl2_col;
      if (clr) begin
        cnt <= '0;
      end else if (en && one_edge) begin
        cnt        <= (side == last_touch) ? cnt + 1'b1 : CW'(1);
        last_touch <= side;
      end
    end
  end

endmodule

// File: rtl/match_judge.sv
// Two-player match judge: awards points on ground or over-touch faults, keeps
// saturating scores and sequences serve / rally / pause / game-over.
module match_judge
  import match_judge_pkg::*;
#(
  parameter int SCORE_W      = 5,
  parameter int WIN_POINTS   = 15,
  parameter int WIN_BY_TWO   = 1,
  parameter int MAX_TOUCHES  = 3,
  parameter int NET_X        = 512,
  parameter int PAUSE_CYCLES = 65_000_000
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               pl1_col,
  input  logic               pl2_col,
  input  logic               gnd_col,
  input  logic [11:0]        ball_xpos,
  input  logic               new_game,
  output logic [SCORE_W-1:0] score_pl1,
  output logic [SCORE_W-1:0] score_pl2,
  output logic               last_touch,
  output logic               ovr_touch,
  output logic               flag_point,
  output logic               point_side,
  output logic               ball_reset,
  output logic               serve_side,
  output logic               freeze,
  output logic               endgame,
  output logic               winner
);
  localparam int          MAX_SCORE = (1 << SCORE_W) - 1;
  localparam int          PW        = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
  localparam logic [11:0] NET_XL    = 12'(NET_X);

  state_t        state;
  logic          gnd_q, gnd_edge, in_rally, over_touch, over_side;
  logic          point, pside, pl1_won, pl2_won;
  logic [PW-1:0] pause_cnt;

  assign gnd_edge = gnd_col & ~gnd_q;
  assign in_rally = (state == ST_RALLY);

  // Ground contact takes priority, so touches in that cycle are not counted.
  match_judge_touch_counter #(.MAX_TOUCHES(MAX_TOUCHES)) u_touch (
    .pclk       (pclk),
    .rst        (rst),
    .clr        (state == ST_SERVE),
    .en         (in_rally && !gnd_edge),
    .pl1_col    (pl1_col),
    .pl2_col    (pl2_col),
    .last_touch (last_touch),
    .over_touch (over_touch),
    .over_side  (over_side)
  );

  always_comb begin
    point = 1'b0;
    pside = PL1;
    if (in_rally) begin
      if (gnd_edge) begin
        point = 1'b1;
        pside = (ball_xpos < NET_XL) ? PL2 : PL1;
      end else if (over_touch) begin
        point = 1'b1;
        pside = ~over_side;
      end
    end
  end

  assign pl1_won = has_won(int'(score_pl1), int'(score_pl2), WIN_POINTS, WIN_BY_TWO != 0, MAX_SCORE);
  assign pl2_won = has_won(int'(score_pl2), int'(score_pl1), WIN_POINTS, WIN_BY_TWO != 0, MAX_SCORE);

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state      <= ST_SERVE;
      gnd_q      <= 1'b0;
      pause_cnt  <= '0;
      score_pl1  <= '0;
      score_pl2  <= '0;
      ovr_touch  <= 1'b0;
      flag_point <= 1'b0;
      point_side <= PL1;
      ball_reset <= 1'b0;
      serve_side <= PL1;
      freeze     <= 1'b0;
      endgame    <= 1'b0;
      winner     <= PL1;
    end else begin
      gnd_q      <= gnd_col;
      flag_point <= 1'b0;
      ovr_touch  <= 1'b0;
      ball_reset <= 1'b0;
      case (state)
        ST_SERVE: begin
          ball_reset <= 1'b1;
          state      <= ST_RALLY;
        end
        ST_RALLY: begin
          if (point) begin
            flag_point <= 1'b1;
            ovr_touch  <= over_touch;
            point_side <= pside;
            serve_side <= pside;
            if (pside == PL1) begin
              if (score_pl1 != '1) score_pl1 <= score_pl1 + 1'b1;
            end else begin
              if (score_pl2 != '1) score_pl2 <= score_pl2 + 1'b1;
            end
            freeze    <= 1'b1;
            pause_cnt <= PW'(PAUSE_CYCLES - 1);
            state     <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (pause_cnt == '0) begin
            if (pl1_won || pl2_won) begin
              endgame <= 1'b1;
              winner  <= pl2_won ? PL2 : PL1;
              state   <= ST_GAME_OVER;
            end else begin
              freeze <= 1'b0;
              state  <= ST_SERVE;
            end
          end else begin
            pause_cnt <= pause_cnt - 1'b1;
          end
        end
        ST_GAME_OVER: begin
          if (new_game) begin
            score_pl1  <= '0;
            score_pl2  <= '0;
            serve_side <= ~winner;
            freeze     <= 1'b0;
            endgame    <= 1'b0;
            state      <= ST_SERVE;
          end
        end
        default: state <= ST_SERVE;
      endcase
    end
  end

endmodule
